// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations, drives decode forward selects,
// load-use stalls, EX bubbles and IF/ID flush. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter  int unsigned REG_ADDR_W = 5,
  parameter  int unsigned NUM_STAGES = 3,
  parameter  int unsigned LOAD_STAGE = 2,
  localparam int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  br_taken,
  input  logic                  ext_stall,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_if,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  logic [NUM_STAGES:1]   e_vld;
  logic [NUM_STAGES:1]   e_we;
  logic [NUM_STAGES:1]   e_ld;
  logic [REG_ADDR_W-1:0] e_rd [1:NUM_STAGES];

  logic [NUM_STAGES:1]   live;
  logic [SEL_W-1:0]      sel1;
  logic [SEL_W-1:0]      sel2;
  logic                  ld_haz1;
  logic                  ld_haz2;
  logic                  hazard;

  // x0 is never a real producer, so it is excluded from liveness up front
  always_comb begin
    live = '0;
    for (int k = 1; k <= int'(NUM_STAGES); k++) begin
      live[k] = e_vld[k] & e_we[k] & (e_rd[k] != '0);
    end
  end

  // Scan oldest to youngest so the youngest matching producer is the final assignment
  always_comb begin
    sel1    = '0;
    sel2    = '0;
    ld_haz1 = 1'b0;
    ld_haz2 = 1'b0;
    for (int k = int'(NUM_STAGES); k >= 1; k--) begin
      if (id_rs1_used && live[k] && (e_rd[k] == id_rs1)) begin
        sel1    = SEL_W'(k);
        ld_haz1 = e_ld[k] && (k < int'(LOAD_STAGE));
      end
      if (id_rs2_used && live[k] && (e_rd[k] == id_rs2)) begin
        sel2    = SEL_W'(k);
        ld_haz2 = e_ld[k] && (k < int'(LOAD_STAGE));
      end
    end
  end

  assign hazard    = id_valid & (ld_haz1 | ld_haz2);
  assign stall_id  = nrst & hazard;
  assign bubble_ex = stall_id & ~ext_stall;
  assign flush_if  = nrst & br_taken & id_valid & ~stall_id & ~ext_stall;
  assign fwd_sel1  = nrst ? sel1 : '0;
  assign fwd_sel2  = nrst ? sel2 : '0;

  // Tracking shift register; a stalled or empty decode slot enters EX as a bubble
  always_ff @(posedge clk) begin
    if (!nrst) begin
      e_vld <= '0;
      e_we  <= '0;
      e_ld  <= '0;
      for (int k = 1; k <= int'(NUM_STAGES); k++) e_rd[k] <= '0;
    end else if (!ext_stall) begin
      e_vld[1] <= id_valid & ~hazard;
      e_we[1]  <= id_valid & ~hazard & id_rd_we;
      e_ld[1]  <= id_valid & ~hazard & id_is_load;
      e_rd[1]  <= (id_valid & ~hazard) ? id_rd : '0;
      for (int k = 2; k <= int'(NUM_STAGES); k++) begin
        e_vld[k] <= e_vld[k-1];
        e_we[k]  <= e_we[k-1];
        e_ld[k]  <= e_ld[k-1];
        e_rd[k]  <= e_rd[k-1];
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(stall_id);
      perf_flush_cnt <= perf_flush_cnt + 32'(flush_if);
    end
  end
`endif

endmodule
